// File: rtl/aes_pkg.sv
// Shared definitions for the AES block feeder: widths, FSM encoding, byte-swap helper.
// The optional byte-swap datapath is enabled with AES_FEEDER_BSWAP_EN.
package aes_pkg;

    localparam int WORD_W = 32;
    localparam int BLK_W  = 128;
    localparam int CNT_W  = 2;

    typedef enum logic [2:0] {
        ST_COLLECT   = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_DRAIN     = 3'd4
    } feeder_state_e;

    function automatic logic [WORD_W-1:0] bswap32(input logic [WORD_W-1:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_block_feeder_if.sv
// Word-stream handshake bundle between the feeder and its producer/consumer.
interface aes_block_feeder_if;
    import aes_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              in_is_key;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic              out_last;

    modport master (
        output in_valid, in_data, in_is_key, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_is_key, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

endinterface

// File: rtl/aes_word_serializer.sv
// 128-to-32 output buffer: emits the most significant word first over valid/ready.
module aes_word_serializer
    import aes_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [BLK_W-1:0]  load_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last,
    output logic              done
);

    logic [BLK_W-1:0] shift_r;
    logic [CNT_W-1:0] cnt_r;
    logic             valid_r;
    logic             last_r;
    logic             hs_s;

    assign hs_s      = valid_r & out_ready;
    assign done      = hs_s & (cnt_r == 2'd3);
    assign out_valid = valid_r;
    assign out_data  = shift_r[BLK_W-1 -: WORD_W];
    assign out_last  = last_r;

    // Load a block, then shift one word out per accepted handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r <= {BLK_W{1'b0}};
            cnt_r   <= 2'd0;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
        end else if (load) begin
            shift_r <= load_data;
            cnt_r   <= 2'd0;
            valid_r <= 1'b1;
            last_r  <= 1'b0;
        end else if (hs_s) begin
            shift_r <= {shift_r[BLK_W-WORD_W-1:0], {WORD_W{1'b0}}};
            cnt_r   <= cnt_r + 2'd1;
            valid_r <= (cnt_r != 2'd3);
            last_r  <= (cnt_r == 2'd2);
        end
    end

endmodule

// File: rtl/aes_block_feeder.sv
// Collects key/data words into 128-bit blocks, drives an AES core and serializes its result.
// Optional AES_FEEDER_BSWAP_EN byte-reverses every input and output word.
module aes_block_feeder
    import aes_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    aes_block_feeder_if.slave    bus,
    input  logic                 cfg_enc,
    output logic                 core_start,
    output logic                 core_enc_dec,
    output logic [BLK_W-1:0]     core_data_in,
    output logic [BLK_W-1:0]     core_key_in,
    input  logic                 core_ready,
    input  logic [BLK_W-1:0]     core_data_out,
    output logic                 key_loaded
);

    feeder_state_e     state_r;
    feeder_state_e     state_nxt_s;
    logic [CNT_W-1:0]  key_cnt_r;
    logic [CNT_W-1:0]  dat_cnt_r;
    logic [CNT_W-1:0]  key_slot_s;
    logic              key_loaded_r;
    logic              blk_full_r;
    logic              in_ready_r;
    logic              core_start_r;
    logic              core_enc_dec_r;
    logic [BLK_W-1:0]  key_r;
    logic [BLK_W-1:0]  blk_r;
    logic [WORD_W-1:0] word_s;
    logic [BLK_W-1:0]  result_s;
    logic              hs_s;
    logic              key_hs_s;
    logic              dat_hs_s;
    logic              key_done_s;
    logic              launch_s;
    logic              in_ready_nxt_s;
    logic              core_start_nxt_s;
    logic              load_s;
    logic              drain_done_s;

`ifdef AES_FEEDER_BSWAP_EN
    assign word_s = bswap32(bus.in_data);

    // Byte-reverse each word of the core result before it is buffered.
    always_comb begin
        result_s = core_data_out;
        for (int i = 0; i < 4; i++) begin
            result_s[i*WORD_W +: WORD_W] = bswap32(core_data_out[i*WORD_W +: WORD_W]);
        end
    end
`else
    assign word_s   = bus.in_data;
    assign result_s = core_data_out;
`endif

    // A full block waiting for a key only lets key words through.
    assign bus.in_ready = in_ready_r & (bus.in_is_key | ~blk_full_r);
    assign hs_s         = bus.in_valid & bus.in_ready;
    assign key_hs_s     = hs_s & bus.in_is_key;
    assign dat_hs_s     = hs_s & ~bus.in_is_key;
    assign key_slot_s   = key_loaded_r ? 2'd0 : key_cnt_r;
    assign key_done_s   = key_hs_s & (key_slot_s == 2'd3);
    assign launch_s     = (dat_hs_s & (dat_cnt_r == 2'd3) & key_loaded_r)
                        | (key_done_s & blk_full_r);

    assign core_start   = core_start_r;
    assign core_enc_dec = core_enc_dec_r;
    assign core_data_in = blk_r;
    assign core_key_in  = key_r;
    assign key_loaded   = key_loaded_r;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_COLLECT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_COLLECT:   if (launch_s)      state_nxt_s = ST_LAUNCH;    else state_nxt_s = ST_COLLECT;
            ST_LAUNCH:    if (core_ready)    state_nxt_s = ST_WAIT_BUSY; else state_nxt_s = ST_LAUNCH;
            ST_WAIT_BUSY: if (!core_ready)   state_nxt_s = ST_WAIT_DONE; else state_nxt_s = ST_WAIT_BUSY;
            ST_WAIT_DONE: if (core_ready)    state_nxt_s = ST_DRAIN;     else state_nxt_s = ST_WAIT_DONE;
            ST_DRAIN:     if (drain_done_s)  state_nxt_s = ST_COLLECT;   else state_nxt_s = ST_DRAIN;
            default:                         state_nxt_s = ST_COLLECT;
        endcase
    end

    // FSM output decode; the results are registered below.
    always_comb begin
        in_ready_nxt_s   = (state_nxt_s == ST_COLLECT);
        core_start_nxt_s = (state_r == ST_LAUNCH) & core_ready;
        load_s           = (state_r == ST_WAIT_DONE) & core_ready;
    end

    // Registered handshake and core control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r     <= 1'b0;
            core_start_r   <= 1'b0;
            core_enc_dec_r <= 1'b0;
        end else begin
            in_ready_r   <= in_ready_nxt_s;
            core_start_r <= core_start_nxt_s;
            if (core_start_nxt_s) begin
                core_enc_dec_r <= cfg_enc;
            end
        end
    end

    // Key and block assembly; registers only change while collecting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_cnt_r    <= 2'd0;
            dat_cnt_r    <= 2'd0;
            key_loaded_r <= 1'b0;
            blk_full_r   <= 1'b0;
            key_r        <= {BLK_W{1'b0}};
            blk_r        <= {BLK_W{1'b0}};
        end else begin
            if (key_hs_s) begin
                for (int i = 0; i < 4; i++) begin
                    if (key_slot_s == i[CNT_W-1:0]) begin
                        key_r[BLK_W-1-WORD_W*i -: WORD_W] <= word_s;
                    end
                end
                key_cnt_r    <= key_slot_s + 2'd1;
                key_loaded_r <= key_done_s;
            end
            if (dat_hs_s) begin
                for (int i = 0; i < 4; i++) begin
                    if (dat_cnt_r == i[CNT_W-1:0]) begin
                        blk_r[BLK_W-1-WORD_W*i -: WORD_W] <= word_s;
                    end
                end
                dat_cnt_r <= dat_cnt_r + 2'd1;
                if ((dat_cnt_r == 2'd3) && !key_loaded_r) begin
                    blk_full_r <= 1'b1;
                end
            end
            if (launch_s) begin
                blk_full_r <= 1'b0;
            end
        end
    end

    aes_word_serializer u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_s),
        .load_data (result_s),
        .out_ready (bus.out_ready),
        .out_valid (bus.out_valid),
        .out_data  (bus.out_data),
        .out_last  (bus.out_last),
        .done      (drain_done_s)
    );

endmodule

// File: tb/tb_aes_block_feeder.sv
// Directed self-checking bench for aes_block_feeder; the bench plays the AES core using FIPS-197 vectors.
module tb_aes_block_feeder;

    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cfg_enc = 1'b1;
    logic         core_start;
    logic         core_enc_dec;
    logic [127:0] core_data_in;
    logic [127:0] core_key_in;
    logic         core_ready = 1'b1;
    logic [127:0] core_data_out = 128'h0;
    logic         key_loaded;
    int           checks = 0;
    int           errors = 0;

    aes_block_feeder_if bus ();

    aes_block_feeder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .cfg_enc       (cfg_enc),
        .core_start    (core_start),
        .core_enc_dec  (core_enc_dec),
        .core_data_in  (core_data_in),
        .core_key_in   (core_key_in),
        .core_ready    (core_ready),
        .core_data_out (core_data_out),
        .key_loaded    (key_loaded)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] sw(input logic [31:0] w);
`ifdef AES_FEEDER_BSWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Present one word and hold it until accepted; returns 1 time unit after the accepting edge.
    task automatic send(input logic k, input logic [31:0] d);
        int n;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_is_key = k;
        bus.in_data   = d;
        #1;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("send_ready", {127'h0, bus.in_ready}, 128'h1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_block(input logic k, input logic [127:0] blk);
        for (int i = 0; i < 4; i++) send(k, sw(blk[127-32*i -: 32]));
    endtask

    // Act as the core starting right after the launching handshake.
    task automatic core_run(input logic [127:0] exp_blk, input logic exp_enc, input logic [127:0] result);
        chk("start_early", {127'h0, core_start}, 128'h0);
        @(posedge clk); #1;
        chk("start_latency", {127'h0, core_start}, 128'h1);
        chk("core_data_in", core_data_in, exp_blk);
        chk("core_key_in", core_key_in, KEY);
        chk("core_enc_dec", {127'h0, core_enc_dec}, {127'h0, exp_enc});
        core_ready = 1'b0;
        @(posedge clk); #1;
        chk("start_pulse", {127'h0, core_start}, 128'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("data_stable", core_data_in, exp_blk);
        chk("key_stable", core_key_in, KEY);
        chk("busy_in_ready", {127'h0, bus.in_ready}, 128'h0);
        chk("busy_out_valid", {127'h0, bus.out_valid}, 128'h0);
        core_data_out = result;
        core_ready    = 1'b1;
        @(posedge clk); #1;
        chk("drain_valid", {127'h0, bus.out_valid}, 128'h1);
    endtask

    // Take four words on consecutive cycles.
    task automatic recv(input logic [127:0] exp);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("out_valid", {127'h0, bus.out_valid}, 128'h1);
            chk("out_data", {96'h0, bus.out_data}, {96'h0, sw(exp[127-32*i -: 32])});
            chk("out_last", {127'h0, bus.out_last}, {127'h0, (i == 3)});
            @(posedge clk); #1;
        end
        chk("drain_end_valid", {127'h0, bus.out_valid}, 128'h0);
        chk("drain_end_in_ready", {127'h0, bus.in_ready}, 128'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_is_key = 1'b0;
        bus.in_data   = 32'h0;
        bus.out_ready = 1'b1;

        // Reset values
        #1;
        chk("rst_in_ready", {127'h0, bus.in_ready}, 128'h0);
        chk("rst_out_valid", {127'h0, bus.out_valid}, 128'h0);
        chk("rst_out_last", {127'h0, bus.out_last}, 128'h0);
        chk("rst_key_loaded", {127'h0, key_loaded}, 128'h0);
        chk("rst_core_start", {127'h0, core_start}, 128'h0);
        chk("rst_core_data_in", core_data_in, 128'h0);
        chk("rst_core_key_in", core_key_in, 128'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", {127'h0, bus.in_ready}, 128'h1);

        // Data before any key: block is held, further data back-pressured
        cfg_enc = 1'b1;
        send_block(1'b0, PT);
        bus.in_valid  = 1'b1;
        bus.in_is_key = 1'b0;
        bus.in_data   = 32'hdeadbeef;
        #1;
        chk("nokey_data_bp", {127'h0, bus.in_ready}, 128'h0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("nokey_no_start", {127'h0, core_start}, 128'h0);
        end
        bus.in_valid = 1'b0;
        chk("nokey_key_loaded", {127'h0, key_loaded}, 128'h0);
        send_block(1'b1, KEY);
        chk("key_loaded_set", {127'h0, key_loaded}, 128'h1);
        bus.out_ready = 1'b0;
        core_run(PT, 1'b1, CT);

        // Back-pressure in DRAIN
        for (int i = 0; i < 10; i++) begin
            chk("hold_data", {96'h0, bus.out_data}, {96'h0, sw(32'h69c4e0d8)});
            chk("hold_in_ready", {127'h0, bus.in_ready}, 128'h0);
            @(posedge clk); #1;
        end
        recv(CT);

        // Decrypt with retained key
        cfg_enc = 1'b0;
        send_block(1'b0, CT);
        core_run(CT, 1'b0, PT);
        recv(PT);

        // Reload key: first new key word clears key_loaded
        send(1'b1, sw(KEY[127:96]));
        chk("key_reload_clear", {127'h0, key_loaded}, 128'h0);
        send(1'b1, sw(KEY[95:64]));
        send(1'b1, sw(KEY[63:32]));
        send(1'b1, sw(KEY[31:0]));
        chk("key_reload_set", {127'h0, key_loaded}, 128'h1);
        cfg_enc = 1'b1;
        send_block(1'b0, PT);
        core_run(PT, 1'b1, CT);
        recv(CT);

        // Reset while waiting for the core result
        send_block(1'b0, PT);
        chk("rw_start_early", {127'h0, core_start}, 128'h0);
        @(posedge clk); #1;
        chk("rw_start", {127'h0, core_start}, 128'h1);
        core_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rw_out_valid", {127'h0, bus.out_valid}, 128'h0);
        chk("rw_key_loaded", {127'h0, key_loaded}, 128'h0);
        chk("rw_in_ready", {127'h0, bus.in_ready}, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        core_data_out = CT;
        core_ready    = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            chk("rw_no_output", {127'h0, bus.out_valid}, 128'h0);
            chk("rw_no_start", {127'h0, core_start}, 128'h0);
        end
        chk("rw_in_ready_after", {127'h0, bus.in_ready}, 128'h1);
        chk("rw_key_cleared", core_key_in, 128'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_block_feeder.md
AES_BLOCK_FEEDER -- requirements
Module: aes_block_feeder

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rst_n  in  1  reset (asynchronous, active-low).
REQ-002 SHALL have port: in_valid  in  1  input word valid.
REQ-003 SHALL have port: in_ready  out  1  input word accepted when in_valid & in_ready.
REQ-004 SHALL have port: in_data  in  32  input word, first word maps to bits [127:96].
REQ-005 SHALL have port: in_is_key  in  1  1 = key word, 0 = plaintext/ciphertext word.
REQ-006 SHALL have port: cfg_enc  in  1  1 = encrypt, 0 = decrypt; sampled at launch.
REQ-007 SHALL have port: core_start  out  1  start pulse to the AES core.
REQ-008 SHALL have port: core_enc_dec  out  1  registered copy of cfg_enc at launch.
REQ-009 SHALL have ports: core_data_in  out  128  assembled block; core_key_in  out  128  key register.
REQ-010 SHALL have ports: core_ready  in  1  core idle/done; core_data_out  in  128  core result.
REQ-011 SHALL have ports: out_valid  out  1; out_ready  in  1; out_data  out  32; out_last  out  1 (set on 4th word).
REQ-012 SHALL have port: key_loaded  out  1  a full 128-bit key is held.

Function
REQ-013 States SHALL be COLLECT, LAUNCH, WAIT_BUSY, WAIT_DONE, DRAIN.
REQ-014 COLLECT: in_ready=1; a key word SHALL load key slot key_cnt and increment the 2-bit key_cnt; a data word SHALL load blk slot dat_cnt and increment dat_cnt.
REQ-015 On the 4th key word key_loaded SHALL be set next cycle; a new key word after that SHALL clear key_loaded and restart at slot 0.
REQ-016 When dat_cnt wraps 3->0 and key_loaded=1 (including a key completing on the same cycle), the FSM SHALL go to LAUNCH; if key_loaded=0, it SHALL stay in COLLECT, accepting key words only (data words back-pressured).
REQ-017 LAUNCH: in_ready=0; when core_ready=1, core_start SHALL be high for exactly one cycle, core_enc_dec latched, then go to WAIT_BUSY.
REQ-018 WAIT_BUSY: on core_ready=0 SHALL go to WAIT_DONE; core_data_in/core_key_in SHALL remain stable from LAUNCH until WAIT_DONE is entered.
REQ-019 WAIT_DONE: on the first cycle core_ready=1, SHALL capture core_data_out into the output buffer and go to DRAIN.
REQ-020 DRAIN: out_valid=1; out_data SHALL present words [127:96],[95:64],[63:32],[31:0] in order; out_data/out_last SHALL be held stable while out_valid & !out_ready.
REQ-021 After the 4th output handshake the FSM SHALL return to COLLECT with dat_cnt=0; the key is retained.
REQ-022 in_ready SHALL be 0 in LAUNCH, WAIT_BUSY, WAIT_DONE and DRAIN.
REQ-023 Latency from the 4th data handshake to core_start SHALL be 2 cycles when core_ready=1.

Reset
REQ-024 On rst_n low: state=COLLECT, counters=0, key_loaded=0, core_start=0, out_valid=0, out_last=0, in_ready=0 during reset; all data/key registers=0.
REQ-025 Reset mid-block SHALL discard partial words and any in-flight result; in_ready SHALL be 1 the first cycle after release.

Configuration
REQ-026 With AES_FEEDER_BSWAP_EN defined, the bytes of each in_data word SHALL be reversed before storing and each out_data word SHALL be byte-reversed; without it, words pass unmodified.

Structure
REQ-027 State encoding, word-count width and the 32/128 width constants SHALL live in shared package aes_pkg.
REQ-028 One sub-module aes_word_serializer (128-to-32 output buffer with valid/ready) is natural; everything else stays inline.

Verification
REQ-029 Key words 00010203,04050607,08090a0b,0c0d0e0f then data 00112233,44556677,8899aabb,ccddeeff, cfg_enc=1 -> out 69c4e0d8,6a7b0430,d8cdb780,70b4c55a, out_last on the 4th word.
REQ-030 Same key, data 69c4e0d8..70b4c55a, cfg_enc=0 -> out 00112233..ccddeeff.
REQ-031 Four data words with no key -> no core_start, in_ready low for data words; load 4 key words -> core_start 2 cycles after the 4th key word.
REQ-032 Hold out_ready=0 for 10 cycles in DRAIN -> out_data stays 69c4e0d8, no in_ready; release -> 4 words in 4 cycles.
REQ-033 Assert rst_n low during WAIT_DONE -> out_valid=0, key_loaded=0; the later core_ready rise produces no output.
REQ-034 With AES_FEEDER_BSWAP_EN defined and byte-swapped vector words (03020100, ...) -> out d8e0c469, 30047b6a, 80b7cdd8, 5ac5b470.
